// File: rtl/div_stall_unit_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider.
package div_stall_unit_pkg;

  // Default operand width and iteration counter width.
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Divider FSM state encodings.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // HI/LO writeback selects. The divider result writes both:
  // the quotient goes to LO and the remainder goes to HI.
  localparam logic [1:0] HILO_WB_NONE = 2'b00;
  localparam logic [1:0] HILO_WB_LO   = 2'b01;
  localparam logic [1:0] HILO_WB_HI   = 2'b10;
  localparam logic [1:0] HILO_WB_BOTH = 2'b11;

endpackage

// File: rtl/div_stall_unit_sign_fix.sv
// Two's-complement conditional negation. Used as absolute value on the
// operand path and as sign restoration on the result path.
module div_sign_fix
  import div_stall_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  // Negate when requested; the most negative value maps onto itself, which
  // is exactly the unsigned magnitude the restoring datapath needs.
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/div_stall_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in EX. Drives the
// div_stall request to the hazard unit and presents quotient (LO) and
// remainder (HI) with a result_valid strobe.
module div_stall_unit
  import div_stall_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] opaE,
  input  logic [WIDTH-1:0] opbE,
  input  logic             annul,
  input  logic             ext_stall,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dvd;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] r_prem;      // partial remainder
  logic [WIDTH-1:0] r_opa_raw;   // original dividend, for divide-by-zero
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div_zero;

  logic             w_start;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_prem_step;
  logic [WIDTH-1:0] w_dvd_step;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_start = startE & ~annul;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a_neg = signedE & opaE[WIDTH-1];
  assign w_b_neg = signedE & opbE[WIDTH-1];

  // Operand magnitudes.
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_val(opaE), .i_neg(w_a_neg), .o_val(w_abs_a));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_val(opbE), .i_neg(w_b_neg), .o_val(w_abs_b));

  // One restoring step: shift, trial-subtract, keep the difference if non-negative.
  assign w_shift     = {r_prem, r_dvd[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_divisor};
  assign w_qbit      = ~w_trial[WIDTH];
  assign w_prem_step = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_dvd_step  = {r_dvd[WIDTH-2:0], w_qbit};

  // Sign restoration of the values produced by the final step.
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_val(w_dvd_step),  .i_neg(r_q_neg), .o_val(w_q_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.i_val(w_prem_step), .i_neg(r_r_neg), .o_val(w_r_fix));

  assign quotient  = r_quot;
  assign remainder = r_rem;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next state: DONE holds under an external stall so the DIV is not re-issued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (w_start) w_state_next = DIV_CALC;
      DIV_CALC: begin
        if (annul)       w_state_next = DIV_IDLE;
        else if (w_last) w_state_next = DIV_DONE;
      end
      DIV_DONE: if (annul || !ext_stall) w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
  end

  // FSM outputs: stall from accepted start through the last step; valid in DONE.
  always_comb begin
    div_stall    = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      DIV_IDLE: div_stall    = w_start;
      DIV_CALC: div_stall    = ~annul;
      DIV_DONE: result_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration on the last step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_divisor  <= '0;
      r_dvd      <= '0;
      r_prem     <= '0;
      r_opa_raw  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_cnt      <= '0;
            r_divisor  <= w_abs_b;
            r_dvd      <= w_abs_a;
            r_prem     <= '0;
            r_opa_raw  <= opaE;
            r_q_neg    <= signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
            r_r_neg    <= w_a_neg;
            r_div_zero <= (opbE == '0);
          end
        end
        DIV_CALC: begin
          // An annulled division leaves the published result untouched.
          if (!annul) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_prem <= w_prem_step;
            r_dvd  <= w_dvd_step;
            if (w_last) begin
              r_quot <= r_div_zero ? '1        : w_q_fix;
              r_rem  <= r_div_zero ? r_opa_raw : w_r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit: scoreboard of expected results
// pushed at issue and popped when the unit reaches DONE.
module tb_div_stall_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        startE;
  logic        signedE;
  logic [31:0] opaE;
  logic [31:0] opbE;
  logic        annul;
  logic        ext_stall;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_q   = '0;
  logic [31:0] last_r   = '0;

  div_stall_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .startE      (startE),
    .signedE     (signedE),
    .opaE        (opaE),
    .opbE        (opbE),
    .annul       (annul),
    .ext_stall   (ext_stall),
    .div_stall   (div_stall),
    .result_valid(result_valid),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference division, including the defined divide-by-zero result.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint q64;
    longint r64;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (sgn) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      q64  = sa / sb_v;
      r64  = sa % sb_v;
      e.q  = q64[31:0];
      e.r  = r64[31:0];
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Issue a division (startE left high) and wait for DONE; exp_gap < 0 skips the gap check.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                input int exp_gap);
    exp_t e;
    int   cnt;
    int   gap;
    bit   seen;
    bit   done;
    sb.push_back(model(a, b, sgn));
    opaE = a; opbE = b; signedE = sgn; startE = 1'b1;
    cnt = 0; gap = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (div_stall) begin
        cnt++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end else begin
        gap++;
      end
      if (!done) @(negedge clk);
    end
    check("done_reached", {63'd0, done}, 64'd1);
    check("stall_cycles", 64'(cnt), 64'd33);
    if (exp_gap >= 0) check("start_gap", 64'(gap), 64'(exp_gap));
    check("result_valid", {63'd0, result_valid}, 64'd1);
    e = sb.pop_front();
    check("quotient", {32'd0, quotient}, {32'd0, e.q});
    check("remainder", {32'd0, remainder}, {32'd0, e.r});
    last_q = e.q;
    last_r = e.r;
    $display("div a=%h b=%h signed=%0d -> q=%h r=%h stall=%0d", a, b, sgn, quotient, remainder, cnt);
  endtask

  // EX advances out of DONE: drop startE, confirm the strobe lasted one cycle.
  task automatic release_ex();
    startE = 1'b0;
    @(negedge clk); #1;
    check("rv_one_cycle", {63'd0, result_valid}, 64'd0);
    check("idle_no_stall", {63'd0, div_stall}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rv_cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    resetn = 1'b0; startE = 1'b0; signedE = 1'b0; opaE = '0; opbE = '0;
    annul = 1'b0; ext_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_div_stall", {63'd0, div_stall}, 64'd0);
    check("rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("rst_quotient", {32'd0, quotient}, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases.
    start_and_wait(32'd100, 32'd7, 1'b0, 0);             release_ex();
    start_and_wait(32'hFFFF_FF9C, 32'd7, 1'b1, 0);       release_ex();
    start_and_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0); release_ex();
    start_and_wait(32'd5, 32'd0, 1'b0, 0);               release_ex();
    start_and_wait(32'hFFFF_FFF9, 32'd0, 1'b1, 0);       release_ex();
    start_and_wait(32'd100, 32'hFFFF_FFF9, 1'b1, 0);     release_ex();

    // Random operands, signed and unsigned, small and large divisors.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(1, 300));
      if (rb == 32'd0) rb = 32'd1;
      start_and_wait(ra, rb, (i < 4), 0);
      release_ex();
    end

    // External stall spanning DONE with startE still high: no re-issue.
    start_and_wait(32'd1000, 32'd33, 1'b0, 0);
    ext_stall = 1'b1;
    rv_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (result_valid) rv_cnt++;
      check("ext_hold_no_stall", {63'd0, div_stall}, 64'd0);
    end
    ext_stall = 1'b0;
    startE = 1'b0;
    @(negedge clk); #1;
    check("ext_rv_cycles", 64'(rv_cnt), 64'd5);
    check("ext_rv_low", {63'd0, result_valid}, 64'd0);
    check("ext_no_reissue", {63'd0, div_stall}, 64'd0);
    check("ext_q_hold", {32'd0, quotient}, {32'd0, last_q});
    $display("ext_stall hold: result_valid cycles=%0d", rv_cnt);

    // Annul at CALC cycle 10: stall drops at once, result untouched.
    opaE = 32'h1234_5678; opbE = 32'h0000_1234; signedE = 1'b0; startE = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    annul = 1'b1; startE = 1'b0;
    #1;
    check("annul_stall_drop", {63'd0, div_stall}, 64'd0);
    check("annul_rv_low", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    check("annul_idle", {63'd0, div_stall}, 64'd0);
    check("annul_rv_idle", {63'd0, result_valid}, 64'd0);
    check("annul_q_hold", {32'd0, quotient}, {32'd0, last_q});
    check("annul_r_hold", {32'd0, remainder}, {32'd0, last_r});
    $display("annul at CALC 10: q=%h r=%h", quotient, remainder);
    start_and_wait(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 0); release_ex();

    // Reset mid-CALC, then back-to-back divisions.
    opaE = 32'd77; opbE = 32'd5; signedE = 1'b0; startE = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    resetn = 1'b0; startE = 1'b0;
    #1;
    check("mid_rst_stall", {63'd0, div_stall}, 64'd0);
    check("mid_rst_rv", {63'd0, result_valid}, 64'd0);
    check("mid_rst_q", {32'd0, quotient}, 64'd0);
    check("mid_rst_r", {32'd0, remainder}, 64'd0);
    $display("reset mid-CALC: q=%h r=%h", quotient, remainder);
    @(negedge clk);
    resetn = 1'b1;
    start_and_wait(32'd9, 32'd3, 1'b0, 0);
    start_and_wait(32'd8, 32'd2, 1'b0, 1);
    release_ex();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Multi-cycle signed/unsigned radix-2 divider in the EX stage.
- Source of the `div_stall` input consumed by the hazard unit. It holds the pipeline through `longest_stall` until the quotient and remainder are ready for HI/LO writeback.
- Also consumes the pipeline's other long stalls and the exception flush, so each division starts exactly once and a flushed division is abandoned.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock.
- resetn  input  1  asynchronous, active-low reset.
- startE  input  1  a DIV/DIVU is in EX; level held while EX is stalled.
- signedE  input  1  1 = DIV (signed), 0 = DIVU.
- opaE  input  WIDTH  dividend (forwarded rs value).
- opbE  input  WIDTH  divisor (forwarded rt value).
- annul  input  1  exception flush; abandons any division in progress.
- ext_stall  input  1  OR of non-divider long stalls (i_stall | d_stall).
- div_stall  output  1  to hazard unit; pipeline must hold.
- result_valid  output  1  one-cycle-or-longer strobe; quotient/remainder valid.
- quotient  output  WIDTH  goes to LO.
- remainder  output  WIDTH  goes to HI.

Behaviour:
- Reset values: state = IDLE, counter = 0, div_stall = 0, result_valid = 0, quotient = 0, remainder = 0, internal registers = 0.
- FSM states:
  - IDLE: on `startE & ~annul`, latch |opaE|, |opbE|, the sign of the quotient (signedE & (opaE[MSB] ^ opbE[MSB])) and the sign of the remainder (signedE & opaE[MSB]); clear the partial remainder; counter = 0; go to CALC.
  - CALC: one restoring step per cycle. Shift {partial remainder, dividend} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative. The counter increments; after WIDTH steps go to DONE and register the sign-corrected quotient and remainder.
  - DONE: result_valid = 1. Stay in DONE while ext_stall = 1; otherwise return to IDLE next cycle.
- div_stall is combinational:
  - asserted as `(IDLE & startE & ~annul) | (CALC & ~annul)`;
  - low in DONE.
- Latency: startE first seen in cycle 0. CALC occupies cycles 1..WIDTH. DONE is cycle WIDTH+1, where div_stall = 0 and EX may advance. div_stall is high for exactly WIDTH+1 cycles (33 at default).
- No restart of the same instruction:
  - DONE holds while ext_stall is high, so a DIV kept in EX by another stall is not re-issued.
  - A back-to-back DIV arriving in the cycle after DONE starts normally from IDLE.
- annul:
  - In CALC, forces IDLE next cycle and drops div_stall in the same cycle; quotient and remainder keep their previous values and result_valid stays 0.
  - In IDLE, suppresses start.
  - In DONE, forces IDLE next cycle.
- Signed correction:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- Divide by zero (divisor 0; MIPS leaves the result undefined, this unit defines it):
  - Still takes the full latency.
  - Quotient = all ones, remainder = dividend; no sign correction applied to either.
- quotient and remainder hold their last values until the next completed division.
- Reset assertion in any state returns to IDLE immediately; all outputs take their reset values.

Decomposition:
- Shared package holds:
  - state encodings DIV_IDLE = 2'b00, DIV_CALC = 2'b01, DIV_DONE = 2'b10;
  - the WIDTH default;
  - the HI/LO writeback select constants.
- One natural sub-module, div_sign_fix: combinational absolute value on input and sign restoration on output. It is reused for the operand and the result paths.
- The restoring datapath, counter and FSM stay in div_stall_unit.

Test Plan:
- DIVU 100/7, startE held until div_stall falls -> div_stall high 33 cycles, then quotient 0x0000000E, remainder 0x00000002, result_valid 1 cycle.
- DIV 0xFFFFFF9C (-100) / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- DIVU 5/0 -> 33-cycle stall, quotient 0xFFFFFFFF, remainder 0x00000005.
- ext_stall high for 4 cycles spanning DONE while startE stays high -> result_valid high 5 cycles, no second division started, div_stall stays 0.
- annul pulsed at CALC cycle 10 -> div_stall drops the same cycle, IDLE next cycle, outputs keep previous values; a new startE then produces a correct result.
- resetn pulsed low mid-CALC, then back-to-back DIVU 9/3 and 8/2 -> both results correct (3 r0, 4 r0), each with a 33-cycle stall and a one-cycle gap for DONE.
